test_reg_port: RTL and testbench

Single-word bidirectional staging register with a mode-qualified enable handshake.
- Read transaction (state=0): captures the word on rd_data into internal storage.
- Write transaction (state=1): presents the stored word on wr_data.
- Used as a simple parameterised data latch between a host-side bus and a consumer, all in one clock domain.

---
 rtl/test_reg_port.sv | 78 +++++++
 tb/tb_test_reg_port.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/test_reg_port.sv
// Single-word staging register: a read transaction captures rd_data when en
// falls, and a write transaction presents the stored word on wr_data.
module test_reg_port #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  state,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACTIVE = 2'd1,
    WR_ACTIVE = 2'd2
  } fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  en_q, en_d;
  logic                  en_fall;

  // en_q is always high while a transaction is active, so en_fall marks the
  // first edge on which en is seen low and therefore the completion edge.
  assign en_fall = en_q & ~en;
  assign wr_data = wr_data_q;

  // Next-state, storage and output-register update.
  always_comb begin
    fsm_d     = fsm_q;
    data_d    = data_q;
    wr_data_d = wr_data_q;
    en_d      = en;
    unique case (fsm_q)
      IDLE: begin
        if (en) begin
          if (state) begin
            fsm_d     = WR_ACTIVE;
            wr_data_d = data_q;
          end else begin
            fsm_d = RD_ACTIVE;
          end
        end
      end
      RD_ACTIVE: begin
        if (en_fall) begin
          data_d = rd_data;
          fsm_d  = IDLE;
        end
      end
      WR_ACTIVE: begin
        if (en_fall) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= IDLE;
      data_q    <= '0;
      wr_data_q <= '0;
      en_q      <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      data_q    <= data_d;
      wr_data_q <= wr_data_d;
      en_q      <= en_d;
    end
  end

endmodule

// File: tb/tb_test_reg_port.sv
// Self-checking bench for test_reg_port: a scoreboard queue holds the word
// each write transaction must present on wr_data.
module tb_test_reg_port;

  localparam int unsigned DATA_WIDTH = 16;

  logic                  clk;
  logic                  reset_n;
  logic                  en;
  logic                  state;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_data;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [DATA_WIDTH-1:0] last_rd;   // word the DUT should currently hold
  logic [DATA_WIDTH-1:0] wr_exp;    // value wr_data should be holding
  logic [DATA_WIDTH-1:0] exp_q[$];  // expected wr_data per write start

  test_reg_port #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .state   (state),
    .rd_data (rd_data),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en and state must never be X/Z while out of reset.
  always @(posedge clk) begin
    if (reset_n === 1'b1)
      assert (!$isunknown({en, state}))
      else $error("illegal X/Z on en/state");
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                       input logic [DATA_WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] rand_word();
    return DATA_WIDTH'($urandom);
  endfunction

  // Read transaction: en high for len edges, then en low with data applied.
  task automatic do_read(input logic [DATA_WIDTH-1:0] data, input int len,
                         input bit toggle);
    @(negedge clk);
    en      = 1'b1;
    state   = 1'b0;
    rd_data = rand_word();
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      check("rd_hold", wr_data, wr_exp);
      @(negedge clk);
      if (toggle) state = ~state;
      rd_data = rand_word();
    end
    en      = 1'b0;
    rd_data = data;
    @(posedge clk); #1;
    check("rd_end", wr_data, wr_exp);
    last_rd = data;
  endtask

  // Write transaction: wr_data must show the stored word one edge after start.
  task automatic do_write(input int len);
    logic [DATA_WIDTH-1:0] exp;
    @(negedge clk);
    en      = 1'b1;
    state   = 1'b1;
    rd_data = rand_word();
    exp_q.push_back(last_rd);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_sb: scoreboard empty");
    end else begin
      exp = exp_q.pop_front();
      check("wr_start", wr_data, exp);
      wr_exp = exp;
    end
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      state   = 1'($urandom);
      rd_data = rand_word();
      @(posedge clk); #1;
      check("wr_hold", wr_data, wr_exp);
    end
    @(negedge clk);
    en      = 1'b0;
    rd_data = rand_word();
    @(posedge clk); #1;
    check("wr_end", wr_data, wr_exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    state    = 1'b0;
    rd_data  = '0;
    last_rd  = '0;
    wr_exp   = '0;

    // Reset held for 10 cycles.
    repeat (10) @(posedge clk);
    #1 check("reset", wr_data, '0);
    @(negedge clk) reset_n = 1'b1;

    // Write before any read after reset.
    do_write(3);

    // Basic read/write.
    do_read(16'h1234, 5, 1'b0);
    do_write(7);

    // Asynchronous reset between edges clears wr_data immediately.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_rst", wr_data, '0);
    last_rd = '0;
    wr_exp  = '0;
    @(negedge clk) reset_n = 1'b1;

    // Boundary words.
    do_read(16'hFFFF, 2, 1'b0);
    do_write(1);
    do_read(16'h0000, 3, 1'b0);
    do_write(2);

    // Fast switching with single-cycle pulses.
    do_read(16'hA5A5, 1, 1'b0);
    do_write(1);

    // state toggled mid-read is ignored.
    do_read(16'h5A3C, 4, 1'b1);
    do_write(2);

    // Reset mid-read aborts the capture.
    @(negedge clk);
    en      = 1'b1;
    state   = 1'b0;
    rd_data = 16'hBEEF;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    en = 1'b0;
    #1 check("mid_rst", wr_data, '0);
    last_rd = '0;
    wr_exp  = '0;
    @(negedge clk) reset_n = 1'b1;
    do_write(1);

    // Random transactions.
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(int'($urandom_range(8, 1)));
      else
        do_read(rand_word(), int'($urandom_range(8, 1)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
